key_filter_bank: RTL and testbench



---
 rtl/key_filter_bank.sv | 169 ++++++++++++++++
 tb/tb_key_filter_bank.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_filter_bank.sv
// key_filter_bank: four-channel push-button debouncer.
// Each active-low raw key is synchronised, filtered by a per-channel
// IDLE/PRESS_FILT/HELD/REL_FILT machine, and presented as a clean level plus
// single-cycle press/release pulses.
// Optional macro KEY_REPEAT_EN adds hold-to-repeat press pulses.
module key_filter_bank #(
  parameter int KEY_W      = 4,
  parameter int CNT_MAX    = 999_999,
  parameter int REPEAT_DLY = 24_999_999,
  parameter int REPEAT_PER = 4_999_999
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release
);

  localparam int CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);

  typedef enum logic [1:0] {IDLE, PRESS_FILT, HELD, REL_FILT} state_t;

  // A zero-length filter or repeat interval has no meaningful behaviour.
  if (CNT_MAX < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_params
    $error("key_filter_bank: CNT_MAX, REPEAT_DLY and REPEAT_PER must be >= 1");
  end

  logic [KEY_W-1:0] sync1;
  logic [KEY_W-1:0] ks;

  // Two-flop synchroniser; resets to the released (high) level.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1 <= '1;
      ks    <= '1;
    end else begin
      sync1 <= key_in;
      ks    <= sync1;
    end
  end

  for (genvar i = 0; i < KEY_W; i++) begin : g_ch
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          enter_held, enter_held_nxt;
    logic          enter_idle, enter_idle_nxt;
    logic          level_q, press_q, release_q;
    logic          rep_fire;

    // Filter next-state: a disagreeing sample during a filter aborts it.
    always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      enter_held_nxt = 1'b0;
      enter_idle_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (!ks[i]) begin
            state_nxt = PRESS_FILT;
            cnt_nxt   = '0;
          end
        end
        PRESS_FILT: begin
          if (ks[i]) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == CNT_TOP) begin
            state_nxt      = HELD;
            cnt_nxt        = '0;
            enter_held_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        HELD: begin
          if (ks[i]) begin
            state_nxt = REL_FILT;
            cnt_nxt   = '0;
          end
        end
        REL_FILT: begin
          if (!ks[i]) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else if (cnt == CNT_TOP) begin
            state_nxt      = IDLE;
            cnt_nxt        = '0;
            enter_idle_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    // Filter state, counter and "just entered" markers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        state      <= IDLE;
        cnt        <= '0;
        enter_held <= 1'b0;
        enter_idle <= 1'b0;
      end else begin
        state      <= state_nxt;
        cnt        <= cnt_nxt;
        enter_held <= enter_held_nxt;
        enter_idle <= enter_idle_nxt;
      end
    end

`ifdef KEY_REPEAT_EN
    localparam int HMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int HW   = $clog2(HMAX + 1);
    logic [HW-1:0] hcnt;
    logic          rep_phase;

    // Repeat fires on the initial delay, then on every period while held.
    always_comb begin
      rep_fire = (state == HELD) && !ks[i] &&
                 (hcnt == (rep_phase ? HW'(REPEAT_PER) : HW'(REPEAT_DLY)));
    end

    // Hold counter: cleared outside HELD, restarted after each repeat pulse.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        hcnt      <= '0;
        rep_phase <= 1'b0;
      end else if (state != HELD) begin
        hcnt      <= '0;
        rep_phase <= 1'b0;
      end else if (rep_fire) begin
        hcnt      <= HW'(1);
        rep_phase <= 1'b1;
      end else if (hcnt != HW'(HMAX)) begin
        hcnt <= hcnt + 1'b1;
      end
    end
`else
    // Without auto-repeat only the entry into HELD produces a press.
    always_comb begin
      rep_fire = 1'b0;
    end
`endif

    // Registered outputs; level covers HELD and the release filter.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        level_q   <= (state == HELD) || (state == REL_FILT);
        press_q   <= enter_held || rep_fire;
        release_q <= enter_idle;
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule

// File: tb/tb_key_filter_bank.sv
// tb_key_filter_bank: directed scenarios plus randomized key bouncing and
// resets, checked every cycle against a run-length model of the debouncer.
module tb_key_filter_bank;

  localparam int KEY_W      = 4;
  localparam int CNT_MAX    = 9;
  localparam int REPEAT_DLY = 20;
  localparam int REPEAT_PER = 5;
  localparam int LAT        = CNT_MAX + 4;
  localparam int STABLE     = CNT_MAX + 2;
`ifdef KEY_REPEAT_EN
  localparam int EXP_REP_PULSES = 8;
`else
  localparam int EXP_REP_PULSES = 1;
`endif

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic [KEY_W-1:0] key_in  = '1;
  logic [KEY_W-1:0] key_level, key_press, key_release;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  key_filter_bank #(
    .KEY_W     (KEY_W),
    .CNT_MAX   (CNT_MAX),
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: a key changes state once the synchronised input has
  // disagreed with the debounced level for STABLE consecutive samples.
  logic [KEY_W-1:0] h1 = '1, h2 = '1;
  logic [KEY_W-1:0] m_pressed = '0, pend_press = '0, pend_rel = '0;
  logic [KEY_W-1:0] exp_level = '0, exp_press = '0, exp_rel = '0;
  int               run    [KEY_W];
  int               anchor [KEY_W];
  logic             s, act;
  int               age;

  always @(posedge sys_clk) begin
    cyc++;
    if (sys_rst) begin
      h1 = '1; h2 = '1;
      m_pressed = '0; pend_press = '0; pend_rel = '0;
      exp_level = '0; exp_press = '0; exp_rel = '0;
      for (int i = 0; i < KEY_W; i++) begin
        run[i] = 0;
        anchor[i] = 0;
      end
    end else begin
      for (int i = 0; i < KEY_W; i++) begin
        s = h2[i];
        exp_level[i] = m_pressed[i];
        exp_press[i] = pend_press[i];
        exp_rel[i]   = pend_rel[i];
        pend_press[i] = 1'b0;
        pend_rel[i]   = 1'b0;
`ifdef KEY_REPEAT_EN
        if (m_pressed[i] && run[i] == 0 && !s) begin
          age = cyc - 1 - anchor[i];
          if (age == REPEAT_DLY ||
              (age > REPEAT_DLY && (age - REPEAT_DLY) % REPEAT_PER == 0))
            exp_press[i] = 1'b1;
        end
`endif
        act = m_pressed[i] ? s : !s;
        if (act) begin
          run[i]++;
          if (run[i] == STABLE) begin
            run[i] = 0;
            if (m_pressed[i]) begin
              m_pressed[i] = 1'b0;
              pend_rel[i]  = 1'b1;
            end else begin
              m_pressed[i]  = 1'b1;
              pend_press[i] = 1'b1;
              anchor[i]     = cyc;
            end
          end
        end else begin
          if (m_pressed[i] && run[i] > 0) anchor[i] = cyc;
          run[i] = 0;
        end
      end
      h2 = h1;
      h1 = key_in;
    end
  end

  // Per-cycle comparison against the model, sampled after the edge.
  always @(posedge sys_clk) begin
    #2;
    checks++;
    if ({key_level, key_press, key_release} !== {exp_level, exp_press, exp_rel}) begin
      errors++;
      $display("FAIL model_cmp cyc=%0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=%b",
               cyc, key_level, key_press, key_release, exp_level, exp_press, exp_rel);
    end
    checks++;
    if ((key_press & key_release) !== '0) begin
      errors++;
      $display("FAIL exclusive cyc=%0d: press=%b release=%b overlap, required none",
               cyc, key_press, key_release);
    end
  end

  task automatic expect_bits(input string name, input logic [KEY_W-1:0] got,
                             input logic [KEY_W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %b expected %b", name, cyc, got, want);
    end
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge sys_clk);
  endtask

  int t0, tf, tl, ts, tr, tp, p, npress, nrel, rst_left;
  int dur [KEY_W];

  initial begin
    step(3);
    expect_bits("reset_level", key_level, 4'b0000);
    expect_bits("reset_press", key_press, 4'b0000);
    expect_bits("reset_release", key_release, 4'b0000);
    sys_rst = 1'b0;
    step(5);

    // Clean press/release on key 0.
    key_in[0] = 1'b0; t0 = cyc + 1;
    wait_cyc(t0 + LAT - 1);
    expect_bits("clean_press_early", key_press, 4'b0000);
    wait_cyc(t0 + LAT);
    expect_bits("clean_press", key_press, 4'b0001);
    expect_bits("clean_level_rise", key_level, 4'b0001);
    expect_bits("model_press_pin", exp_press, 4'b0001);
    wait_cyc(t0 + 49);
    key_in[0] = 1'b1;
    wait_cyc(t0 + 50 + LAT);
    expect_bits("clean_release", key_release, 4'b0001);
    expect_bits("clean_level_fall", key_level, 4'b0000);
    expect_bits("model_release_pin", exp_rel, 4'b0001);
    step(5);

    // Bounce bursts on key 1, then stable low.
    for (int b = 0; b < 3; b++) begin
      key_in[1] = 1'b0; step(8);
      key_in[1] = 1'b1; step(2);
    end
    expect_bits("bounce_no_level", key_level, 4'b0000);
    key_in[1] = 1'b0; tf = cyc + 1;
    wait_cyc(tf + LAT);
    expect_bits("bounce_press", key_press, 4'b0010);
    key_in[1] = 1'b1;
    step(LAT + 5);

    // Filter window boundary: one sample short is rejected, exact is accepted.
    key_in[1] = 1'b0; step(STABLE - 1);
    key_in[1] = 1'b1; step(LAT + 5);
    expect_bits("short_low_level", key_level, 4'b0000);
    key_in[1] = 1'b0; tl = cyc + 1; step(STABLE);
    key_in[1] = 1'b1;
    wait_cyc(tl + LAT);
    expect_bits("exact_low_press", key_press, 4'b0010);
    step(LAT + 5);

    // All keys together.
    key_in = '0; ts = cyc + 1;
    wait_cyc(ts + LAT);
    expect_bits("simul_press", key_press, 4'b1111);
    expect_bits("simul_level", key_level, 4'b1111);

    // Release bounce on key 3 while held.
    key_in[3] = 1'b1; step(5);
    key_in[3] = 1'b0;
    for (int c = 0; c < 18; c++) begin
      step(1);
      expect_bits("relb_level", key_level & 4'b1000, 4'b1000);
      expect_bits("relb_pulses", (key_press | key_release) & 4'b1000, 4'b0000);
    end

    // Reset while keys are held.
    sys_rst = 1'b1;
    #1;
    expect_bits("async_rst_level", key_level, 4'b0000);
    expect_bits("async_rst_release", key_release, 4'b0000);
    step(3);
    sys_rst = 1'b0; tr = cyc + 1;
    wait_cyc(tr + LAT);
    expect_bits("rst_repress", key_press, 4'b1111);
    key_in = '1;
    step(LAT + 5);
    expect_bits("all_released", key_level, 4'b0000);

    // Hold-to-repeat on key 0.
    key_in[0] = 1'b0; tp = cyc + 1; p = tp + LAT;
    npress = 0; nrel = 0;
    for (int c = p; c <= p + 70; c++) begin
      wait_cyc(c);
      if (c == p + 49) key_in[0] = 1'b1;
      npress += int'(key_press[0]);
      nrel   += int'(key_release[0]);
    end
    expect_int("repeat_press_count", npress, EXP_REP_PULSES);
    expect_int("repeat_release_count", nrel, 1);
    step(5);

    // Randomized bouncing with occasional resets.
    rst_left = 0;
    for (int i = 0; i < KEY_W; i++) dur[i] = $urandom_range(0, 20);
    for (int c = 0; c < 3000; c++) begin
      @(negedge sys_clk);
      if (sys_rst) begin
        if (rst_left == 0) sys_rst = 1'b0;
        else rst_left--;
      end else if ($urandom_range(0, 799) == 0) begin
        sys_rst  = 1'b1;
        rst_left = $urandom_range(0, 2);
      end
      for (int i = 0; i < KEY_W; i++) begin
        if (dur[i] == 0) begin
          key_in[i] = ~key_in[i];
          dur[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12)
                                                : $urandom_range(12, 40);
        end else begin
          dur[i]--;
        end
      end
    end

    sys_rst = 1'b0;
    key_in  = '1;
    step(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
